// File: rtl/io_clk_p.sv
// Clocking constants shared between the clock recovery block and its controllers.
package io_clk_p;
  parameter int unsigned CYCLE_BITWIDTH = 8;
endpackage

// File: rtl/sys_structs.sv
// Shared system structures: clock domain bundle (clock, synchronous reset, clock enable).
package sys_structs;
  typedef struct packed {
    logic clk;
    logic sync_rst;
    logic clk_en;
  } clk_domain;
endpackage

// File: rtl/recovery_link_controller.sv
// Link sequencer for the clock recovery block: config load, framing hunt, frame tracking
// and a timed resync with latched error codes after recovery violations.
module recovery_link_controller #(
  parameter int unsigned CYCLE_BITWIDTH  = io_clk_p::CYCLE_BITWIDTH,
  parameter int unsigned BIT_COUNT_WIDTH = 12,
  parameter int unsigned ERR_COUNT_WIDTH = 8,
  parameter int unsigned RESYNC_CYCLES   = 16,
  parameter int unsigned HUNT_TIMEOUT    = 4096
) (
  input  sys_structs::clk_domain     clk_dom_i,
  input  logic                       link_enable_i,
  input  logic [CYCLE_BITWIDTH-1:0]  preemptive_cfg_i,
  input  logic                       pause_start_i,
  input  logic                       short_pause_i,
  input  logic                       long_pause_i,
  input  logic                       overflow_i,
  input  logic                       underflow_i,
  input  logic                       freq_violation_i,
  input  logic                       tick_input_i,
  input  logic                       tick_output_i,
  output logic                       recovery_enable_o,
  output logic [CYCLE_BITWIDTH-1:0]  preemptive_count_o,
  output logic                       link_up_o,
  output logic                       frame_active_o,
  output logic                       frame_start_o,
  output logic                       frame_end_o,
  output logic [BIT_COUNT_WIDTH-1:0] frame_bits_o,
  output logic                       error_o,
  output logic [3:0]                 error_code_o,
  output logic [ERR_COUNT_WIDTH-1:0] error_count_o,
  output logic                       hunt_timeout_o
);

  localparam int unsigned HuntW   = (HUNT_TIMEOUT > 1) ? $clog2(HUNT_TIMEOUT) : 1;
  localparam int unsigned ResyncW = (RESYNC_CYCLES > 1) ? $clog2(RESYNC_CYCLES) : 1;
  localparam logic [HuntW-1:0]   HuntLast   = HuntW'(HUNT_TIMEOUT - 1);
  localparam logic [ResyncW-1:0] ResyncLast = ResyncW'(RESYNC_CYCLES - 1);

  typedef enum logic [2:0] {
    StDisabled, StLoad, StHunt, StIdleBus, StFrame, StPause, StError
  } state_e;

  state_e                     state_q, state_d;
  logic [HuntW-1:0]           hunt_cnt_q;
  logic [ResyncW-1:0]         resync_cnt_q;
  logic                       recovery_enable_q, link_up_q, frame_active_q;
  logic                       frame_start_q, frame_end_q, error_q, hunt_timeout_q;
  logic [CYCLE_BITWIDTH-1:0]  preemptive_count_q;
  logic [BIT_COUNT_WIDTH-1:0] frame_bits_q;
  logic [3:0]                 error_code_q;
  logic [ERR_COUNT_WIDTH-1:0] error_count_q;

  logic       violation, proto_err, err_entry, hunt_fire, frame_start, frame_end, count_tick;
  logic [3:0] err_cause;

  always_comb begin
    violation   = overflow_i | underflow_i | freq_violation_i;
    proto_err   = (state_q == StPause) && tick_input_i;
    err_entry   = link_enable_i && (state_q inside {StFrame, StPause}) && (violation || proto_err);
    err_cause   = {proto_err, freq_violation_i, underflow_i, overflow_i};
    state_d     = state_q;
    hunt_fire   = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    if (!link_enable_i) begin
      state_d = StDisabled;
    end else if (err_entry) begin
      state_d = StError;
    end else begin
      unique case (state_q)
        StDisabled: state_d = StLoad;
        StLoad:     state_d = StHunt;
        StHunt: begin
          if (long_pause_i) begin
            state_d = StIdleBus;
          end else if (hunt_cnt_q == HuntLast) begin
            hunt_fire = 1'b1;
          end
        end
        StIdleBus: begin
          if (tick_input_i || tick_output_i) begin
            state_d     = StFrame;
            frame_start = 1'b1;
          end
        end
        StFrame: if (pause_start_i) state_d = StPause;
        StPause: begin
          if (short_pause_i) begin
            state_d   = StIdleBus;
            frame_end = 1'b1;
          end
        end
        StError:  if (resync_cnt_q == ResyncLast) state_d = StHunt;
        default:  state_d = StDisabled;
      endcase
    end
    // Ticks are counted only while the frame survives the cycle.
    count_tick = (state_q == StFrame) && tick_input_i && (state_d inside {StFrame, StPause});
  end

  always_ff @(posedge clk_dom_i.clk) begin
    if (clk_dom_i.sync_rst) begin
      state_q            <= StDisabled;
      hunt_cnt_q         <= '0;
      resync_cnt_q       <= '0;
      recovery_enable_q  <= 1'b0;
      link_up_q          <= 1'b0;
      frame_active_q     <= 1'b0;
      frame_start_q      <= 1'b0;
      frame_end_q        <= 1'b0;
      error_q            <= 1'b0;
      hunt_timeout_q     <= 1'b0;
      preemptive_count_q <= '0;
      frame_bits_q       <= '0;
      error_code_q       <= '0;
      error_count_q      <= '0;
    end else if (clk_dom_i.clk_en) begin
      state_q           <= state_d;
      // Status outputs follow the state being entered, giving a one-cycle response.
      recovery_enable_q <= state_d inside {StHunt, StIdleBus, StFrame, StPause};
      link_up_q         <= state_d inside {StIdleBus, StFrame, StPause};
      frame_active_q    <= state_d inside {StFrame, StPause};
      frame_start_q     <= frame_start;
      frame_end_q       <= frame_end;
      error_q           <= err_entry;
      hunt_timeout_q    <= hunt_fire;
      hunt_cnt_q   <= (state_q == StHunt && state_d == StHunt && !hunt_fire) ?
                      hunt_cnt_q + 1'b1 : '0;
      resync_cnt_q <= (state_q == StError && state_d == StError) ? resync_cnt_q + 1'b1 : '0;
      if (state_q == StLoad) begin
        preemptive_count_q <= preemptive_cfg_i;
      end
      if (frame_start) begin
        frame_bits_q <= BIT_COUNT_WIDTH'(tick_input_i);
      end else if (count_tick && frame_bits_q != '1) begin
        frame_bits_q <= frame_bits_q + 1'b1;
      end
      if (err_entry) begin
        error_code_q <= err_cause;
        if (error_count_q != '1) begin
          error_count_q <= error_count_q + 1'b1;
        end
      end
    end
  end

  assign recovery_enable_o  = recovery_enable_q;
  assign preemptive_count_o = preemptive_count_q;
  assign link_up_o          = link_up_q;
  assign frame_active_o     = frame_active_q;
  assign frame_start_o      = frame_start_q;
  assign frame_end_o        = frame_end_q;
  assign frame_bits_o       = frame_bits_q;
  assign error_o            = error_q;
  assign error_code_o       = error_code_q;
  assign error_count_o      = error_count_q;
  assign hunt_timeout_o     = hunt_timeout_q;

endmodule

// File: tb/tb_recovery_link_controller.sv
// Bench for recovery_link_controller: a behavioural link model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_recovery_link_controller;
  localparam int unsigned CW     = io_clk_p::CYCLE_BITWIDTH;
  localparam int          BitMax = 4095;
  localparam int          ErrMax = 255;
  localparam int          Resync = 16;
  localparam int          HuntTo = 4096;

  // Event bit positions: {tick_in, tick_out, pause_start, short, long, ovf, udf, freq}
  localparam logic [7:0] EvTin = 8'h80, EvTout = 8'h40, EvPst = 8'h20, EvSps = 8'h10;
  localparam logic [7:0] EvLps = 8'h08, EvOvf = 8'h04, EvUdf = 8'h02, EvFrq = 8'h01;

  logic clk = 1'b0, sync_rst = 1'b1, clk_en = 1'b0;
  sys_structs::clk_domain clk_dom;
  assign clk_dom = '{clk: clk, sync_rst: sync_rst, clk_en: clk_en};

  logic          link_enable = 1'b0;
  logic [CW-1:0] preemptive_cfg = '0;
  logic pause_start = 1'b0, short_pause = 1'b0, long_pause = 1'b0;
  logic overflow = 1'b0, underflow = 1'b0, freq_violation = 1'b0;
  logic tick_input = 1'b0, tick_output = 1'b0;

  logic          recovery_enable, link_up, frame_active, frame_start, frame_end;
  logic          error_p, hunt_timeout;
  logic [CW-1:0] preemptive_count;
  logic [11:0]   frame_bits;
  logic [3:0]    error_code;
  logic [7:0]    error_count;

  recovery_link_controller #(
    .CYCLE_BITWIDTH (CW),
    .BIT_COUNT_WIDTH(12),
    .ERR_COUNT_WIDTH(8),
    .RESYNC_CYCLES  (16),
    .HUNT_TIMEOUT   (4096)
  ) dut (
    .clk_dom_i         (clk_dom),
    .link_enable_i     (link_enable),
    .preemptive_cfg_i  (preemptive_cfg),
    .pause_start_i     (pause_start),
    .short_pause_i     (short_pause),
    .long_pause_i      (long_pause),
    .overflow_i        (overflow),
    .underflow_i       (underflow),
    .freq_violation_i  (freq_violation),
    .tick_input_i      (tick_input),
    .tick_output_i     (tick_output),
    .recovery_enable_o (recovery_enable),
    .preemptive_count_o(preemptive_count),
    .link_up_o         (link_up),
    .frame_active_o    (frame_active),
    .frame_start_o     (frame_start),
    .frame_end_o       (frame_end),
    .frame_bits_o      (frame_bits),
    .error_o           (error_p),
    .error_code_o      (error_code),
    .error_count_o     (error_count),
    .hunt_timeout_o    (hunt_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {MOff, MLoad, MHunt, MIdle, MFrame, MPause, MErr} mmode_e;
  mmode_e        mode = MOff;
  int            hunt_left = 0, resync_left = 0;
  int            e_bits = 0, e_cnt = 0;
  logic [3:0]    e_code = '0;
  logic [CW-1:0] e_pre = '0;
  logic e_ren = 0, e_link = 0, e_act = 0, e_fs = 0, e_fe = 0, e_err = 0, e_ht = 0;

  always @(posedge clk) begin : model
    mmode_e        nm;
    int            nh, nr, nbits, ncnt;
    logic [3:0]    ncode, cause;
    logic [CW-1:0] npre;
    logic          fs, fe, er, ht;
    nm = mode; nh = hunt_left; nr = resync_left; nbits = e_bits; ncnt = e_cnt;
    ncode = e_code; npre = e_pre;
    fs = 1'b0; fe = 1'b0; er = 1'b0; ht = 1'b0;
    cause = {(mode == MPause) && tick_input, freq_violation, underflow, overflow};
    if (!link_enable) begin
      nm = MOff;
    end else if ((mode == MFrame || mode == MPause) && cause != 4'b0) begin
      nm = MErr; nr = Resync; er = 1'b1; ncode = cause;
      if (ncnt < ErrMax) ncnt = ncnt + 1;
    end else begin
      case (mode)
        MOff:  nm = MLoad;
        MLoad: begin npre = preemptive_cfg; nm = MHunt; nh = HuntTo; end
        MHunt: begin
          if (long_pause) nm = MIdle;
          else begin
            nh = nh - 1;
            if (nh == 0) begin ht = 1'b1; nh = HuntTo; end
          end
        end
        MIdle: if (tick_input || tick_output) begin
          nm = MFrame; fs = 1'b1; nbits = tick_input ? 1 : 0;
        end
        MFrame: begin
          if (tick_input && nbits < BitMax) nbits = nbits + 1;
          if (pause_start) nm = MPause;
        end
        MPause: if (short_pause) begin nm = MIdle; fe = 1'b1; end
        MErr: begin
          nr = nr - 1;
          if (nr == 0) begin nm = MHunt; nh = HuntTo; end
        end
        default: ;
      endcase
    end
    if (sync_rst) begin
      mode <= MOff; hunt_left <= 0; resync_left <= 0; e_bits <= 0; e_cnt <= 0;
      e_code <= '0; e_pre <= '0; e_ren <= 0; e_link <= 0; e_act <= 0;
      e_fs <= 0; e_fe <= 0; e_err <= 0; e_ht <= 0;
    end else if (clk_en) begin
      mode <= nm; hunt_left <= nh; resync_left <= nr; e_bits <= nbits; e_cnt <= ncnt;
      e_code <= ncode; e_pre <= npre;
      e_ren  <= (nm == MHunt || nm == MIdle || nm == MFrame || nm == MPause);
      e_link <= (nm == MIdle || nm == MFrame || nm == MPause);
      e_act  <= (nm == MFrame || nm == MPause);
      e_fs <= fs; e_fe <= fe; e_err <= er; e_ht <= ht;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("m.recovery_enable", 32'(recovery_enable), 32'(e_ren));
      check("m.preemptive_count", 32'(preemptive_count), 32'(e_pre));
      check("m.link_up", 32'(link_up), 32'(e_link));
      check("m.frame_active", 32'(frame_active), 32'(e_act));
      check("m.frame_start", 32'(frame_start), 32'(e_fs));
      check("m.frame_end", 32'(frame_end), 32'(e_fe));
      check("m.frame_bits", 32'(frame_bits), 32'(e_bits));
      check("m.error", 32'(error_p), 32'(e_err));
      check("m.error_code", 32'(error_code), 32'(e_code));
      check("m.error_count", 32'(error_count), 32'(e_cnt));
      check("m.hunt_timeout", 32'(hunt_timeout), 32'(e_ht));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic pulse(input logic [7:0] ev);
    {tick_input, tick_output, pause_start, short_pause,
     long_pause, overflow, underflow, freq_violation} = ev;
    step(1);
    {tick_input, tick_output, pause_start, short_pause,
     long_pause, overflow, underflow, freq_violation} = 8'h00;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step(2);
    chk_on = 1'b1;
    check("reset link_up", 32'(link_up), 0);
    check("reset recovery_enable", 32'(recovery_enable), 0);
    check("reset frame_bits", 32'(frame_bits), 0);
    sync_rst = 1'b0;
    clk_en   = 1'b1;

    // Config load: LOAD for one cycle, then HUNT with the latched count.
    link_enable = 1'b1; preemptive_cfg = 3;
    step(1);
    check("load recovery_enable", 32'(recovery_enable), 0);
    step(1);
    check("cfg preemptive_count", 32'(preemptive_count), 3);
    check("cfg recovery_enable", 32'(recovery_enable), 1);
    preemptive_cfg = 5;

    // Hunt timeout on the 4096th HUNT cycle.
    step(4095);
    check("hunt before timeout", 32'(hunt_timeout), 0);
    step(1);
    check("hunt timeout pulse", 32'(hunt_timeout), 1);
    check("hunt still enabled", 32'(recovery_enable), 1);
    step(1);
    check("hunt pulse ends", 32'(hunt_timeout), 0);
    check("cfg held", 32'(preemptive_count), 3);

    // Normal frame.
    pulse(EvLps);
    check("frame link_up", 32'(link_up), 1);
    pulse(EvTout);
    check("frame start pulse", 32'(frame_start), 1);
    check("frame start bits", 32'(frame_bits), 0);
    repeat (8) pulse(EvTin);
    check("frame bits 8", 32'(frame_bits), 8);
    pulse(EvPst);
    check("pause frame_active", 32'(frame_active), 1);
    pulse(EvSps);
    check("frame end pulse", 32'(frame_end), 1);
    check("frame end inactive", 32'(frame_active), 0);
    step(3);
    check("frame bits held", 32'(frame_bits), 8);

    // Frequency violation mid-frame.
    pulse(EvTout);
    pulse(EvTin);
    pulse(EvFrq);
    check("freq error pulse", 32'(error_p), 1);
    check("freq error code", 32'(error_code), 4'b0100);
    check("freq error count", 32'(error_count), 1);
    check("freq recovery off", 32'(recovery_enable), 0);
    step(15);
    check("resync still off", 32'(recovery_enable), 0);
    step(1);
    check("resync back in hunt", 32'(recovery_enable), 1);
    check("resync link down", 32'(link_up), 0);

    // Protocol error, then overflow colliding with short pause.
    pulse(EvLps); pulse(EvTout); pulse(EvTin); pulse(EvPst);
    pulse(EvTin);
    check("proto error code", 32'(error_code), 4'b1000);
    check("proto error count", 32'(error_count), 2);
    step(16);
    pulse(EvLps); pulse(EvTout); pulse(EvPst);
    pulse(EvOvf | EvSps);
    check("ovf error code", 32'(error_code), 4'b0001);
    check("ovf no frame_end", 32'(frame_end), 0);
    check("ovf error pulse", 32'(error_p), 1);
    step(16);

    // Link drop mid-frame.
    pulse(EvLps); pulse(EvTin); pulse(EvTin);
    check("drop bits 2", 32'(frame_bits), 2);
    link_enable = 1'b0;
    step(1);
    check("drop recovery off", 32'(recovery_enable), 0);
    check("drop link down", 32'(link_up), 0);
    check("drop no frame_end", 32'(frame_end), 0);
    link_enable = 1'b1;
    step(2);
    check("reload recovery on", 32'(recovery_enable), 1);
    check("reload cfg 5", 32'(preemptive_count), 5);

    // Stall mid-frame: ticks while clk_en is low are not counted.
    pulse(EvLps); pulse(EvTout);
    repeat (3) pulse(EvTin);
    clk_en = 1'b0; tick_input = 1'b1;
    step(10);
    check("stall bits frozen", 32'(frame_bits), 3);
    check("stall frame_active", 32'(frame_active), 1);
    tick_input = 1'b0; clk_en = 1'b1;
    step(1);
    check("after stall bits", 32'(frame_bits), 3);

    // Reset mid-frame with clk_en low.
    clk_en = 1'b0; sync_rst = 1'b1;
    step(1);
    check("rst frame_bits", 32'(frame_bits), 0);
    check("rst recovery_enable", 32'(recovery_enable), 0);
    check("rst link_up", 32'(link_up), 0);
    check("rst preemptive", 32'(preemptive_count), 0);
    check("rst error_count", 32'(error_count), 0);
    check("rst error_code", 32'(error_code), 0);
    check("rst frame_active", 32'(frame_active), 0);
    sync_rst = 1'b0; clk_en = 1'b1;
    step(2);

    // Error counter saturation.
    for (int i = 0; i < 300; i++) begin
      pulse(EvLps); pulse(EvTout); pulse(EvUdf);
      step(16);
    end
    check("sat error_count", 32'(error_count), 255);
    check("sat error_code", 32'(error_code), 4'b0010);

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/recovery_link_controller.md
# recovery_link_controller

Sequencer and framing controller for the clock recovery block. Owns its `recovery_enable` and buffered preemptive-cycle configuration, hunts for bus framing (long pause), and tracks frames between pauses. It counts received bits from `tick_input`, and converts recovery violations into a timed resync with latched error codes. It sits between the recovery block and the link/packet layer.

## Interface
Parameters:
- `CYCLE_BITWIDTH`, default `io_clk_p::CYCLE_BITWIDTH`: width of the preemptive cycle count.
- `BIT_COUNT_WIDTH`, default 12: width of the frame bit counter.
- `ERR_COUNT_WIDTH`, default 8: width of the error counter.
- `RESYNC_CYCLES`, default 16: number of enabled cycles recovery is held disabled after an error.
- `HUNT_TIMEOUT`, default 4096: number of enabled cycles in HUNT before `hunt_timeout_o` fires.

Ports:
- `clk_dom_i` in `sys_structs::clk_domain`: single clock `clk`; `sync_rst` is the reset, synchronous and active-high; `clk_en` is the qualifier.
- `link_enable_i` in 1: level; starts or stops the link.
- `preemptive_cfg_i` in `CYCLE_BITWIDTH`: preemptive output cycle count, sampled in LOAD only.
- `pause_start_i`, `short_pause_i`, `long_pause_i` in 1 each: recovery pause pulses.
- `overflow_i`, `underflow_i`, `freq_violation_i` in 1 each: recovery violation levels/pulses.
- `tick_input_i`, `tick_output_i` in 1 each: recovery tick pulses.
- `recovery_enable_o` out 1: drives the recovery enable.
- `preemptive_count_o` out `CYCLE_BITWIDTH`: buffered config to recovery.
- `link_up_o` out 1: high in IDLE_BUS, FRAME or PAUSE.
- `frame_active_o` out 1: high in FRAME or PAUSE.
- `frame_start_o` out 1: pulse.
- `frame_end_o` out 1: pulse.
- `frame_bits_o` out `BIT_COUNT_WIDTH`: bit count of the current or last frame.
- `error_o` out 1: pulse on error entry.
- `error_code_o` out 4: {protocol, freq, underflow, overflow}; latched until the next error.
- `error_count_o` out `ERR_COUNT_WIDTH`: saturating error count.
- `hunt_timeout_o` out 1: pulse.

## Operation
States: DISABLED, LOAD, HUNT, IDLE_BUS, FRAME, PAUSE, ERROR.

Transitions:
- DISABLED → LOAD when `link_enable_i`=1.
- LOAD (one cycle): latch `preemptive_cfg_i` into `preemptive_count_o`, then → HUNT. `recovery_enable_o` stays 0 in LOAD.
- HUNT: `recovery_enable_o`=1.
  - `long_pause_i` → IDLE_BUS.
  - A timeout counter counts enabled cycles. At `HUNT_TIMEOUT`-1, pulse `hunt_timeout_o`, clear the counter, and stay in HUNT.
  - Violations are ignored while the recovery block converges.
- IDLE_BUS: `tick_input_i` or `tick_output_i` → FRAME, pulse `frame_start_o`, and load `frame_bits_o` = `tick_input_i` ? 1 : 0. Violations are ignored.
- FRAME:
  - Each `tick_input_i` increments `frame_bits_o`, saturating at all-ones.
  - `pause_start_i` → PAUSE. A tick in the same cycle is still counted.
- PAUSE:
  - `short_pause_i` → IDLE_BUS and pulse `frame_end_o`. `frame_bits_o` holds until the next `frame_start_o`.
  - `tick_input_i` before `short_pause_i` is a protocol error.
- In FRAME or PAUSE, any of `overflow_i`/`underflow_i`/`freq_violation_i`=1 → ERROR:
  - `error_code_o` = the OR-snapshot of the causes in that cycle.
  - `error_o` pulses.
  - `error_count_o` increments, saturating.
- ERROR:
  - `recovery_enable_o`=0 for `RESYNC_CYCLES` enabled cycles, then → HUNT.
  - A frame aborted by an error produces no `frame_end_o`.

Priority, highest first:
1. `sync_rst`
2. `link_enable_i`=0: any state → DISABLED next cycle; no `frame_end_o`; `recovery_enable_o`=0.
3. Violation or protocol error.
4. Normal transitions.

Simultaneous events:
- Violation together with `short_pause_i`: ERROR wins.
- Violation together with `pause_start_i`: ERROR wins.
- `long_pause_i` outside HUNT has no effect.

## Timing
- All registers update on `clk` when `sync_rst || clk_en`. While `clk_en`=0, state, counters and outputs freeze; pulses do not repeat.
- Every output is registered. Response latency is exactly 1 enabled cycle after the input event.
  - Example: `long_pause_i` at cycle N gives `link_up_o`=1 at N+1.
- `recovery_enable_o` goes 1 exactly 2 enabled cycles after `link_enable_i` rises from DISABLED (LOAD, then HUNT).
- Reset values, all outputs: 0. State = DISABLED; all counters = 0.
- `sync_rst` mid-frame: everything returns to reset values next cycle, with no `frame_end_o`.
- `preemptive_count_o` changes only in LOAD, so it is stable whenever `recovery_enable_o`=1.
- The ERROR hold counter counts `RESYNC_CYCLES` cycles, 0..`RESYNC_CYCLES`-1, with `recovery_enable_o`=0 throughout. HUNT is entered on the following cycle.
- The error counter saturates at 2^`ERR_COUNT_WIDTH`-1 with no wrap. The bit counter saturates likewise.

## Test plan
- **Config load:** reset; `link_enable_i`=1 with `preemptive_cfg_i`=3. Expect one cycle of LOAD, then `preemptive_count_o`=3 and `recovery_enable_o`=1 at enabled cycle 2. Change cfg to 5 later: `preemptive_count_o` stays 3.
- **Normal frame:** `long_pause_i` → `link_up_o`=1. Then `tick_output_i`, 8× `tick_input_i`, `pause_start_i`, `short_pause_i`. Expect one `frame_start_o` pulse, one `frame_end_o` pulse, and `frame_bits_o`=8 held afterwards.
- **Frequency violation:** `freq_violation_i` in FRAME. Expect `error_o` pulse, `error_code_o`=4'b0100, `error_count_o`=1, `recovery_enable_o`=0 for 16 cycles, then HUNT with `recovery_enable_o`=1 and no `frame_end_o`.
- **Protocol error:** `tick_input_i` in PAUSE before `short_pause_i`. Expect `error_code_o`=4'b1000. Simultaneous `overflow_i` and `short_pause_i` in PAUSE: expect ERROR with code 4'b0001 and no `frame_end_o`.
- **Hunt timeout and disable:** no `long_pause_i` for 4096 enabled cycles. Expect a `hunt_timeout_o` pulse at cycle 4096, still in HUNT. Drop `link_enable_i` mid-FRAME: expect DISABLED and `recovery_enable_o`=0 next cycle, with no `frame_end_o`.
- **Stall and reset:** hold `clk_en`=0 for 10 cycles mid-FRAME; expect all outputs frozen and no ticks counted. Assert `sync_rst` mid-FRAME with `clk_en`=0; expect all outputs 0 next cycle. Force 300 errors; expect `error_count_o` to saturate at 255.
